mxn_shift_seq: RTL and testbench
================================

MXN_SHIFT_SEQ -- requirements
Module: mxn_shift_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the lane width in bits; legal values are powers of two, 4 or more.
REQ-002 The block SHALL have parameter SETS, default 4, giving the number of independent lanes.
REQ-003 The block SHALL derive local constant AMT_W = log2(WIDTH), the per-lane shift-amount width.
REQ-004 Port clk SHALL be an input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port rst SHALL be an input, 1 bit: reset, synchronous and active-high.
REQ-006 Port in_valid SHALL be an input, 1 bit: an operation is offered.
REQ-007 Port in_ready SHALL be an output, 1 bit: the block accepts an operation.
REQ-008 Port in_packed SHALL be an input, SETS*WIDTH bits: lane i operand at [i*WIDTH +: WIDTH].
REQ-009 Port amt_packed SHALL be an input, SETS*AMT_W bits: lane i shift amount, 0..WIDTH-1.
REQ-010 Port dir_packed SHALL be an input, SETS bits: per-lane direction, 0 = left, 1 = right.
REQ-011 Port fill_packed SHALL be an input, SETS bits: per-lane shift-in bit for FILL mode.
REQ-012 Port mode SHALL be an input, 2 bits: 00 LOGICAL, 01 ARITH, 10 ROTATE, 11 FILL; one value for all lanes.
REQ-013 Port out_valid SHALL be an output, 1 bit: the result is presented.
REQ-014 Port out_ready SHALL be an input, 1 bit: the consumer takes the result.
REQ-015 Port out_packed SHALL be an output, SETS*WIDTH bits: the shifted lanes.
REQ-016 Port overflow_packed SHALL be an output, SETS*WIDTH bits: the per-lane bits ejected past the boundary.

Function
REQ-017 The FSM SHALL have three states, IDLE, SHIFT and DONE; in_ready SHALL equal (state==IDLE) and !rst.
REQ-018 When in_valid and in_ready are both high at an edge, the block SHALL latch operands, amounts, directions, fills and mode, clear the overflow registers, and go to SHIFT.
REQ-019 In SHIFT, each lane whose remaining count is nonzero SHALL shift one bit per edge and decrement its count; lanes at zero hold.
REQ-020 In SHIFT, when every remaining count is zero, the next edge SHALL move the FSM to DONE; latency from the accept edge to out_valid high SHALL be max(amt)+1 edges, so all-zero amounts give 1 edge.
REQ-021 The shift-in bit for a left shift SHALL be: 0 for LOGICAL, ARITH and FILL-with-fill=0; the ejected MSB for ROTATE; the fill bit for FILL.
REQ-022 The shift-in bit for a right shift SHALL be: 0 for LOGICAL; the current MSB for ARITH; the ejected LSB for ROTATE; the fill bit for FILL.
REQ-023 For each left step, overflow SHALL update as {ovf[WIDTH-2:0], data[WIDTH-1]}; the final value equals the operand >> (WIDTH-n).
REQ-024 For each right step, overflow SHALL update as {data[0], ovf[WIDTH-1:1]}; the final value equals the operand << (WIDTH-n), truncated.
REQ-025 A lane with amount 0 SHALL pass its operand unchanged, with overflow 0.
REQ-026 In DONE, out_valid SHALL be 1 and out_packed/overflow_packed SHALL hold stable until out_ready is high at an edge; that edge SHALL move the FSM to IDLE.
REQ-027 in_valid outside IDLE SHALL be ignored; input changes after accept SHALL NOT affect the result.
REQ-028 The block SHALL NOT accept a new operation in the cycle a result is consumed; it accepts from IDLE only.
REQ-029 out_packed and overflow_packed SHALL retain the last result in IDLE.

Reset
REQ-030 While rst is high at an edge, the state SHALL become IDLE, and out_valid, out_packed, overflow_packed and all lane counts SHALL become 0, regardless of state, including mid-SHIFT or DONE.
REQ-031 An operation interrupted by rst SHALL be discarded; in_ready SHALL be 1 in the first cycle after rst is released.

Structure
REQ-032 Package shift_pkg SHALL hold the mode encodings (MODE_LOGICAL=0, MODE_ARITH=1, MODE_ROTATE=2, MODE_FILL=3) and the state encodings.
REQ-033 Sub-module shift_lane SHALL hold one lane's data, overflow and count registers plus the one-bit step logic; mxn_shift_seq SHALL instantiate it SETS times in a generate loop and hold the FSM and the all-zero reduction.

Verification (WIDTH=8, SETS=2)
REQ-034 The bench SHALL check LOGICAL left, lane0 0xB5 amt 3 -> out 0xA8, ovf 0x05, out_valid 4 edges after accept.
REQ-035 The bench SHALL check ARITH right, lane0 0x96 amt 2 -> out 0xE5, ovf 0x80; lane1 0x96 dir left amt 2 -> out 0x58, ovf 0x02.
REQ-036 The bench SHALL check ROTATE, lane0 0x81 left amt 1 and lane1 0x3C amt 0 -> lane0 out 0x03, ovf 0x01; lane1 out 0x3C, ovf 0x00; latency 2 edges.
REQ-037 The bench SHALL check FILL right, fill=1, 0x00 amt 4 -> out 0xF0, ovf 0x00; mixed lanes amt 7 and amt 0 -> latency 8 edges.
REQ-038 The bench SHALL check that holding out_ready low 5 cycles in DONE keeps outputs stable, keeps in_ready 0, and ignores in_valid pulses; one out_ready edge returns the FSM to IDLE.
REQ-039 The bench SHALL check that rst asserted in the 2nd SHIFT cycle of an amt 7 operation gives IDLE, all outputs 0 and out_valid 0 on the next edge; a fresh operation then completes correctly.

Source files
------------

// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_pkg
//  Description : Mode and FSM state encodings for the multi-lane shifter.
//  Revision    : 1.0 - initial release
// ============================================================================
package shift_pkg;

    localparam logic [1:0] MODE_LOGICAL = 2'd0;
    localparam logic [1:0] MODE_ARITH   = 2'd1;
    localparam logic [1:0] MODE_ROTATE  = 2'd2;
    localparam logic [1:0] MODE_FILL    = 2'd3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/shift_lane.sv
`default_nettype none
// ============================================================================
//  Module      : shift_lane
//  Description : One lane: data, overflow and count registers, one bit per step.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_lane
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_operand,
    input  logic [AMT_W-1:0] i_amt,
    input  logic             i_dir,
    input  logic             i_fill,
    input  logic [1:0]       i_mode,
    output logic [WIDTH-1:0] o_data,
    output logic [WIDTH-1:0] o_ovf,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_ovf;
    logic [AMT_W-1:0] r_cnt;
    logic             r_dir;
    logic             r_fill;

    logic             w_sin;
    logic [WIDTH-1:0] w_data_nxt;
    logic [WIDTH-1:0] w_ovf_nxt;

    // Shift-in bit: ejected bit for rotate, sign for arithmetic right, fill bit for fill.
    always_comb begin
        w_sin = 1'b0;
        if (!r_dir) begin
            case (i_mode)
                MODE_ROTATE: w_sin = r_data[WIDTH-1];
                MODE_FILL:   w_sin = r_fill;
                default:     w_sin = 1'b0;
            endcase
        end else begin
            case (i_mode)
                MODE_ARITH:  w_sin = r_data[WIDTH-1];
                MODE_ROTATE: w_sin = r_data[0];
                MODE_FILL:   w_sin = r_fill;
                default:     w_sin = 1'b0;
            endcase
        end
    end

    always_comb begin
        if (!r_dir) begin
            w_data_nxt = {r_data[WIDTH-2:0], w_sin};
            w_ovf_nxt  = {r_ovf[WIDTH-2:0], r_data[WIDTH-1]};
        end else begin
            w_data_nxt = {w_sin, r_data[WIDTH-1:1]};
            w_ovf_nxt  = {r_data[0], r_ovf[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_ovf  <= '0;
            r_cnt  <= '0;
            r_dir  <= 1'b0;
            r_fill <= 1'b0;
        end else if (i_load) begin
            r_data <= i_operand;
            r_ovf  <= '0;
            r_cnt  <= i_amt;
            r_dir  <= i_dir;
            r_fill <= i_fill;
        end else if (i_step && (r_cnt != '0)) begin
            r_data <= w_data_nxt;
            r_ovf  <= w_ovf_nxt;
            r_cnt  <= r_cnt - AMT_W'(1);
        end
    end

    assign o_data = r_data;
    assign o_ovf  = r_ovf;
    assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/mxn_shift_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mxn_shift_seq
//  Description : SETS independent WIDTH-bit bit-serial shifters behind one FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
module mxn_shift_seq
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SETS  = 4,
    localparam int AMT_W = $clog2(WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SETS*WIDTH-1:0]   in_packed,
    input  logic [SETS*AMT_W-1:0]   amt_packed,
    input  logic [SETS-1:0]         dir_packed,
    input  logic [SETS-1:0]         fill_packed,
    input  logic [1:0]              mode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SETS*WIDTH-1:0]   out_packed,
    output logic [SETS*WIDTH-1:0]   overflow_packed
);

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [1:0]      r_mode;
    logic            w_load;
    logic            w_step;
    logic [SETS-1:0] w_lane_zero;
    logic            w_all_zero;

    assign w_all_zero = &w_lane_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (in_valid)   w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (w_all_zero) w_state_nxt = ST_DONE;
            ST_DONE:  if (out_ready)  w_state_nxt = ST_IDLE;
            default:                  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == ST_IDLE) && !rst;
        out_valid = (r_state == ST_DONE);
        w_load    = in_ready && in_valid;
        w_step    = (r_state == ST_SHIFT);
    end

    // Mode is shared by all lanes, so it is captured once here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode <= MODE_LOGICAL;
        end else if (w_load) begin
            r_mode <= mode;
        end
    end

    generate
        for (genvar gi = 0; gi < SETS; gi++) begin : g_lane
            shift_lane #(
                .WIDTH (WIDTH),
                .AMT_W (AMT_W)
            ) u_lane (
                .clk       (clk),
                .rst       (rst),
                .i_load    (w_load),
                .i_step    (w_step),
                .i_operand (in_packed[gi*WIDTH +: WIDTH]),
                .i_amt     (amt_packed[gi*AMT_W +: AMT_W]),
                .i_dir     (dir_packed[gi]),
                .i_fill    (fill_packed[gi]),
                .i_mode    (r_mode),
                .o_data    (out_packed[gi*WIDTH +: WIDTH]),
                .o_ovf     (overflow_packed[gi*WIDTH +: WIDTH]),
                .o_zero    (w_lane_zero[gi])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mxn_shift_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mxn_shift_seq
//  Description : Scoreboard bench for mxn_shift_seq (WIDTH=8, SETS=2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mxn_shift_seq;

    localparam int WIDTH = 8;
    localparam int SETS  = 2;
    localparam int AMT_W = 3;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [SETS*WIDTH-1:0] in_packed = '0;
    logic [SETS*AMT_W-1:0] amt_packed = '0;
    logic [SETS-1:0]       dir_packed = '0;
    logic [SETS-1:0]       fill_packed = '0;
    logic [1:0]            mode = 2'd0;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic [SETS*WIDTH-1:0] out_packed;
    logic [SETS*WIDTH-1:0] overflow_packed;

    mxn_shift_seq #(.WIDTH(WIDTH), .SETS(SETS)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_packed       (in_packed),
        .amt_packed      (amt_packed),
        .dir_packed      (dir_packed),
        .fill_packed     (fill_packed),
        .mode            (mode),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_packed      (out_packed),
        .overflow_packed (overflow_packed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] out;
        logic [15:0] ovf;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          have = 0;
    bit          retained = 0;
    logic [15:0] last_out = '0;
    logic [15:0] last_ovf = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: whole-word shift arithmetic on one lane.
    function automatic logic [7:0] ref_out(input logic [7:0] x, input int n,
                                           input logic d, input logic f, input logic [1:0] m);
        logic [7:0] r;
        int         mask;
        if (!d) begin
            r = x << n;
            if (m == 2'd2) r = r | (x >> (8 - n));
            else if (m == 2'd3 && f) begin
                mask = (1 << n) - 1;
                r = r | mask[7:0];
            end
        end else begin
            r = x >> n;
            if (m == 2'd1) r = $signed(x) >>> n;
            else if (m == 2'd2) r = r | (x << (8 - n));
            else if (m == 2'd3 && f) begin
                mask = 255 >> n;
                r = r | ~mask[7:0];
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] ref_ovf(input logic [7:0] x, input int n, input logic d);
        logic [7:0] r;
        if (n == 0)  r = 8'h00;
        else if (!d) r = x >> (8 - n);
        else         r = x << (8 - n);
        return r;
    endfunction

    // Monitor: pops one expectation per result and checks it every DONE cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (!have) begin
                    have = 1;
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: got out=%h with empty queue", out_packed);
                        cur = '{out: out_packed, ovf: overflow_packed, lat: 0, acc: 0};
                    end else begin
                        cur = q.pop_front();
                        chk("latency", cyc - cur.acc, cur.lat);
                    end
                end
                chk("out_packed", out_packed, cur.out);
                chk("overflow_packed", overflow_packed, cur.ovf);
                chk("in_ready_in_done", in_ready, 1'b0);
            end else begin
                if (have) begin
                    have = 0;
                    last_out = cur.out;
                    last_ovf = cur.ovf;
                    retained = 1;
                end
                if (in_ready && retained) begin
                    chk("idle_out_retained", out_packed, last_out);
                    chk("idle_ovf_retained", overflow_packed, last_ovf);
                end
            end
        end
    end

    task automatic wait_ready();
        int t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) chk("wait_in_ready_timeout", in_ready, 1'b1);
    endtask

    task automatic op(input logic [15:0] x, input logic [5:0] a, input logic [1:0] d,
                      input logic [1:0] f, input logic [1:0] m, input int hold, input bit pulse);
        exp_t e;
        int   mx;
        int   t;
        wait_ready();
        in_packed = x; amt_packed = a; dir_packed = d; fill_packed = f; mode = m;
        in_valid = 1'b1;
        @(posedge clk); #1;
        mx = 0;
        for (int i = 0; i < SETS; i++) begin
            int n;
            n = int'(a[3*i +: 3]);
            e.out[8*i +: 8] = ref_out(x[8*i +: 8], n, d[i], f[i], m);
            e.ovf[8*i +: 8] = ref_ovf(x[8*i +: 8], n, d[i]);
            if (n > mx) mx = n;
        end
        e.lat = mx + 1;
        e.acc = cyc;
        q.push_back(e);
        in_valid = 1'b0;
        in_packed = 16'($urandom); amt_packed = 6'($urandom); dir_packed = 2'($urandom);
        fill_packed = 2'($urandom); mode = 2'($urandom);
        t = 0;
        while (!out_valid && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        if (!out_valid) chk("wait_out_valid_timeout", out_valid, 1'b1);
        for (int k = 0; k < hold; k++) begin
            in_valid = pulse ? 1'($urandom) : 1'b0;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        in_valid = pulse;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_out_packed", out_packed, 16'h0);
        chk("reset_ovf_packed", overflow_packed, 16'h0);
        chk("reset_in_ready_held", in_ready, 1'b0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_reset", in_ready, 1'b1);
        last_out = '0; last_ovf = '0; retained = 1;

        // LOGICAL left 0xB5 by 3; lane1 idle
        op(16'h00_B5, {3'd0, 3'd3}, 2'b00, 2'b00, 2'd0, 1, 0);
        // ARITH: lane0 right by 2, lane1 left by 2
        op(16'h96_96, {3'd2, 3'd2}, 2'b01, 2'b00, 2'd1, 0, 0);
        // ROTATE: lane0 0x81 left 1, lane1 0x3C amt 0
        op(16'h3C_81, {3'd0, 3'd1}, 2'b00, 2'b00, 2'd2, 2, 0);
        // FILL right with 1s
        op(16'h00_00, {3'd0, 3'd4}, 2'b01, 2'b01, 2'd3, 0, 0);
        // Mixed amounts 7 and 0
        op(16'hA5_5A, {3'd0, 3'd7}, 2'b10, 2'b11, 2'd3, 1, 0);
        // Held in DONE with in_valid pulses
        op(16'hC3_E1, {3'd5, 3'd2}, 2'b10, 2'b00, 2'd2, 5, 1);

        // Reset during the second SHIFT cycle of an amt-7 operation
        wait_ready();
        in_packed = 16'h5A_5A; amt_packed = {3'd3, 3'd7}; dir_packed = 2'b00;
        fill_packed = 2'b00; mode = 2'd0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        retained = 0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midshift_rst_out_valid", out_valid, 1'b0);
        chk("midshift_rst_out_packed", out_packed, 16'h0);
        chk("midshift_rst_ovf_packed", overflow_packed, 16'h0);
        rst = 1'b0;
        #1;
        chk("midshift_rst_in_ready", in_ready, 1'b1);
        last_out = '0; last_ovf = '0; retained = 1;
        op(16'h12_F0, {3'd1, 3'd6}, 2'b01, 2'b00, 2'd1, 0, 0);

        for (int r = 0; r < 40; r++) begin
            op(16'($urandom), 6'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
               int'($urandom_range(0, 3)), 1'($urandom));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
